// File: rtl/vga_hvsync_generator.sv
// VGA raster timing generator.
// Free-running horizontal and vertical pixel counters. The sync pulses are
// active low and registered, so they lag the counters by one clock.
// display_on is decoded combinationally from the counters and has no lag.
module vga_hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_BACK    = 48,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int V_DISPLAY = 480,
    parameter int V_TOP     = 33,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam logic [9:0] H_DISP_L     = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_DISP_L     = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;

    logic w_hmaxed;
    logic w_vmaxed;
    logic w_hsync_window;
    logic w_vsync_window;

    // End-of-line / end-of-frame and sync window decode from the current counters.
    always_comb begin
        w_hmaxed       = (r_hpos == H_MAX);
        w_vmaxed       = (r_vpos == V_MAX);
        w_hsync_window = (r_hpos >= H_SYNC_START) && (r_hpos <= H_SYNC_END);
        w_vsync_window = (r_vpos >= V_SYNC_START) && (r_vpos <= V_SYNC_END);
    end

    // Pixel counters: hpos every clock, vpos only on the line wrap; reset wins over wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (w_hmaxed) begin
            r_hpos <= '0;
            r_vpos <= w_vmaxed ? 10'd0 : r_vpos + 10'd1;
        end else begin
            r_hpos <= r_hpos + 10'd1;
        end
    end

    // Registered active-low syncs from the pre-edge counter values; reset ends any pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= ~w_hsync_window;
            r_vsync <= ~w_vsync_window;
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = (r_hpos < H_DISP_L) && (r_vpos < V_DISP_L);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator.
// A default-timing instance covers the 640x480 line boundaries from a vector
// table; a shrunken-timing instance makes whole frames cheap and is compared
// every cycle against a time-index model (pixel number since reset).
module tb_vga_hvsync_generator;

    // Small timing: 32 clocks per line, 19 lines per frame.
    localparam int S_HD = 20, S_HB = 4, S_HF = 3, S_HS = 5;
    localparam int S_VD = 12, S_VT = 3, S_VB = 2, S_VS = 2;
    localparam int S_HT  = S_HD + S_HB + S_HF + S_HS;
    localparam int S_VTT = S_VD + S_VT + S_VB + S_VS;
    localparam int S_HSS = S_HD + S_HF;
    localparam int S_HSE = S_HSS + S_HS - 1;
    localparam int S_VSS = S_VD + S_VB;
    localparam int S_VSE = S_VSS + S_VS - 1;
    localparam int S_FRAME = S_HT * S_VTT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_hsync, b_vsync, b_de;
    logic [9:0] b_hpos, b_vpos;
    logic       s_hsync, s_vsync, s_de;
    logic [9:0] s_hpos, s_vpos;

    int n_pass = 0;
    int n_total = 0;

    // model state for the small instance
    int m_t = 0;
    bit m_hs = 1'b1;
    bit m_vs = 1'b1;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    vga_hvsync_generator u_big (
        .clk(clk), .reset(reset), .hsync(b_hsync), .vsync(b_vsync),
        .display_on(b_de), .hpos(b_hpos), .vpos(b_vpos)
    );

    vga_hvsync_generator #(
        .H_DISPLAY(S_HD), .H_BACK(S_HB), .H_FRONT(S_HF), .H_SYNC(S_HS),
        .V_DISPLAY(S_VD), .V_TOP(S_VT), .V_BOTTOM(S_VB), .V_SYNC(S_VS)
    ) u_small (
        .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_de), .hpos(s_hpos), .vpos(s_vpos)
    );

    typedef struct {
        bit rst;
        int cycles;
        int h;
        int v;
        int hs;
        int vs;
        int de;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_small();
        int h, v;
        h = m_t % S_HT;
        v = m_t / S_HT;
        chk("s_hpos", int'(s_hpos), h);
        chk("s_vpos", int'(s_vpos), v);
        chk("s_hsync", int'(s_hsync), int'(m_hs));
        chk("s_vsync", int'(s_vsync), int'(m_vs));
        chk("s_display_on", int'(s_de), int'(h < S_HD && v < S_VD));
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic step();
        int h, v;
        @(posedge clk);
        if (reset) begin
            m_t = 0; m_hs = 1'b1; m_vs = 1'b1; m_valid = 1'b1;
        end else begin
            h = m_t % S_HT;
            v = m_t / S_HT;
            m_hs = !(h >= S_HSS && h <= S_HSE);
            m_vs = !(v >= S_VSS && v <= S_VSE);
            m_t = (m_t + 1) % S_FRAME;
        end
        @(negedge clk);
        if (m_valid) check_small();
    endtask

    initial begin
        int vs_fall [$];
        int hs_falls_between;
        int hs_low_run, hs_bad_width, vs_low_run, vs_low_first;
        int cyc;
        bit found;
        bit prev_hs, prev_vs;

        // default-timing boundaries along the first line
        tbl[0] = '{1'b1,   3,   0, 0, 1, 1, 1};
        tbl[1] = '{1'b0,   1,   1, 0, 1, 1, 1};
        tbl[2] = '{1'b0, 638, 639, 0, 1, 1, 1};
        tbl[3] = '{1'b0,   1, 640, 0, 1, 1, 0};
        tbl[4] = '{1'b0,  16, 656, 0, 1, 1, 0};
        tbl[5] = '{1'b0,   1, 657, 0, 0, 1, 0};
        tbl[6] = '{1'b0,  95, 752, 0, 0, 1, 0};
        tbl[7] = '{1'b0,   1, 753, 0, 1, 1, 0};
        tbl[8] = '{1'b0,  47,   0, 1, 1, 1, 1};

        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst;
            for (int c = 0; c < tbl[i].cycles; c++) step();
            chk($sformatf("vec%0d_hpos", i), int'(b_hpos), tbl[i].h);
            chk($sformatf("vec%0d_vpos", i), int'(b_vpos), tbl[i].v);
            chk($sformatf("vec%0d_hsync", i), int'(b_hsync), tbl[i].hs);
            chk($sformatf("vec%0d_vsync", i), int'(b_vsync), tbl[i].vs);
            chk($sformatf("vec%0d_de", i), int'(b_de), tbl[i].de);
        end

        // randomized run with occasional resets on the small instance
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            step();
        end

        // mid-sync reset: wait for vsync low with hsync low at the first sync line
        reset = 1'b1; step(); reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            step();
            if (int'(s_vpos) == S_VSS && s_hsync == 1'b0) found = 1'b1;
        end
        chk("midsync_found", int'(found), 1);
        chk("midsync_vsync_low", int'(s_vsync), 0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midsync_hpos", int'(s_hpos), 0);
        chk("midsync_vpos", int'(s_vpos), 0);
        chk("midsync_hsync", int'(s_hsync), 1);
        chk("midsync_vsync", int'(s_vsync), 1);
        step();
        chk("midsync_resume", int'(s_hpos), 1);

        // frame periodicity, pulse counts and widths over several frames
        hs_falls_between = 0; hs_low_run = 0; hs_bad_width = 0;
        vs_low_run = 0; vs_low_first = -1;
        prev_hs = s_hsync; prev_vs = s_vsync;
        cyc = 0;
        while (vs_fall.size() < 3 && cyc < 4 * S_FRAME) begin
            step();
            cyc++;
            if (prev_vs && !s_vsync) begin
                vs_fall.push_back(cyc);
                chk("vsync_fall_hpos", int'(s_hpos), 1);
                chk("vsync_fall_vpos", int'(s_vpos), S_VSS);
            end
            if (prev_hs && !s_hsync) begin
                chk("hsync_fall_hpos", int'(s_hpos), S_HSS + 1);
                if (vs_fall.size() == 1) hs_falls_between++;
            end
            if (!s_hsync) hs_low_run++;
            else begin
                if (!prev_hs && hs_low_run != S_HS) hs_bad_width++;
                hs_low_run = 0;
            end
            if (!s_vsync) vs_low_run++;
            else begin
                if (!prev_vs && vs_low_first < 0) vs_low_first = vs_low_run;
                vs_low_run = 0;
            end
            prev_hs = s_hsync; prev_vs = s_vsync;
        end
        chk("vsync_falls_seen", vs_fall.size(), 3);
        if (vs_fall.size() == 3) begin
            chk("frame_period_1", vs_fall[1] - vs_fall[0], S_FRAME);
            chk("frame_period_2", vs_fall[2] - vs_fall[1], S_FRAME);
        end
        chk("hsync_pulses_per_frame", hs_falls_between, S_VTT);
        chk("hsync_bad_widths", hs_bad_width, 0);
        chk("vsync_low_clocks", vs_low_first, S_VS * S_HT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
